// File: rtl/u_lsu_dmem_if.sv
// rtl/u_lsu_dmem_if.sv - load/store bus between the execute stage and the data memory
// Signals:
//   lsu_a    byte address from the initiator (word index = lsu_a[AW+1:2])
//   lsu_we   byte-lane write enables, nonzero = write request
//   lsu_wd   write data, lane i = bits [8i+7:8i]
//   lsu_re   byte-lane read enables, nonzero = read request
//   lsu_vld  one-cycle read data valid pulse from the responder
//   lsu_rd   read data, held until the next response
//   busy     responder not idle; the initiator must not issue requests
// master = initiator (execute stage), slave = responder (data memory)
interface u_lsu_dmem_if;
   logic [31:0] lsu_a;
   logic [3:0]  lsu_we;
   logic [31:0] lsu_wd;
   logic [3:0]  lsu_re;
   logic        lsu_vld;
   logic [31:0] lsu_rd;
   logic        busy;

   modport master (
      output lsu_a, lsu_we, lsu_wd, lsu_re,
      input  lsu_vld, lsu_rd, busy
   );

   modport slave (
      input  lsu_a, lsu_we, lsu_wd, lsu_re,
      output lsu_vld, lsu_rd, busy
   );
endinterface

// File: rtl/u_lsu_dmem.sv
// rtl/u_lsu_dmem.sv - data-memory responder with byte-lane access and read wait states
// Ports:
//   clk      clock
//   rstn     asynchronous active-low reset (array contents are not reset)
//   lsu      load/store bus, slave side (see u_lsu_dmem_if)
//   err_clr  synchronous clear of both sticky error flags
//   err_ovr  sticky: request while busy, or write and read enables together
//   err_oor  sticky: request address outside the array
// Parameters:
//   AW       word-address width, array holds 2**AW 32-bit words
//   WAIT_RD  extra wait cycles before the read response (0..15)
module u_lsu_dmem #(
   parameter int AW      = 10,
   parameter int WAIT_RD = 1
) (
   input  logic         clk,
   input  logic         rstn,
   u_lsu_dmem_if.slave  lsu,
   input  logic         err_clr,
   output logic         err_ovr,
   output logic         err_oor
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [AW-1:0]   idx_q;
   logic [3:0]      re_q;
   logic            inr_q;
   logic [31:0]     rd_q;
   logic [31:0]     mem [2**AW];

   logic            wr_req, rd_req, req, in_range, idle;
   logic            do_wr, accept_rd, load_rd;
   logic [AW-1:0]   req_idx, rd_idx;
   logic [3:0]      rd_re;
   logic            rd_inr;
   logic [31:0]     rd_mask;
   logic            set_ovr, set_oor;
   logic            unused_addr_lsb;

   assign unused_addr_lsb = &{1'b0, lsu.lsu_a[1:0]};

   assign wr_req    = |lsu.lsu_we;
   assign rd_req    = |lsu.lsu_re;
   assign req       = wr_req | rd_req;
   assign in_range  = (lsu.lsu_a[31:AW+2] == '0);
   assign req_idx   = lsu.lsu_a[AW+1:2];
   assign idle      = (state_q == IDLE);
   // A combined write+read still performs the write; only the read is dropped.
   assign do_wr     = idle & wr_req & in_range;
   assign accept_rd = idle & rd_req & ~wr_req;

   // With no wait states the response word is fetched at the accept edge,
   // before the request fields have been latched, so bypass the latches.
   assign rd_idx = idle ? req_idx  : idx_q;
   assign rd_re  = idle ? lsu.lsu_re : re_q;
   assign rd_inr = idle ? in_range : inr_q;

   always_comb begin
      rd_mask = '0;
      for (int i = 0; i < 4; i++) begin
         rd_mask[8*i +: 8] = {8{rd_re[i]}};
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept_rd) begin
               if (WAIT_RD == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_RD - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // RESP is only ever entered from IDLE or WAIT, so this fires once per read.
   assign load_rd = (state_d == RESP);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         re_q    <= '0;
         inr_q   <= 1'b0;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept_rd) begin
            idx_q <= req_idx;
            re_q  <= lsu.lsu_re;
            inr_q <= in_range;
         end
         if (load_rd) begin
            rd_q <= rd_inr ? (mem[rd_idx] & rd_mask) : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (do_wr && lsu.lsu_we[i]) begin
            mem[req_idx][8*i +: 8] <= lsu.lsu_wd[8*i +: 8];
         end
      end
   end

   // Range is only judged for requests the responder actually takes.
   assign set_ovr = req & (~idle | (wr_req & rd_req));
   assign set_oor = req & idle & ~in_range;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         err_ovr <= 1'b0;
         err_oor <= 1'b0;
      end else begin
         err_ovr <= set_ovr | (err_ovr & ~err_clr);
         err_oor <= set_oor | (err_oor & ~err_clr);
      end
   end

   assign lsu.lsu_vld = (state_q == RESP);
   assign lsu.lsu_rd  = rd_q;
   assign lsu.busy    = ~idle;
endmodule

// File: tb/tb_u_lsu_dmem.sv
// tb/tb_u_lsu_dmem.sv - self-checking bench for u_lsu_dmem at WAIT_RD = 1, 0 and 3
module tb_u_lsu_dmem;
   localparam int N = 3;

   function automatic int wait_of(int g);
      return (g == 0) ? 1 : ((g == 1) ? 0 : 3);
   endfunction

   logic        clk = 1'b0;
   logic        rstn;
   logic [31:0] a, wd;
   logic [3:0]  we, re;
   logic        err_clr;

   logic [N-1:0]       vld_o, busy_o, ovr_o, oor_o;
   logic [N-1:0][31:0] rd_o;

   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_dut
         u_lsu_dmem_if bus ();
         assign bus.lsu_a  = a;
         assign bus.lsu_we = we;
         assign bus.lsu_wd = wd;
         assign bus.lsu_re = re;
         assign vld_o[g]   = bus.lsu_vld;
         assign rd_o[g]    = bus.lsu_rd;
         assign busy_o[g]  = bus.busy;
         u_lsu_dmem #(.AW(10), .WAIT_RD(wait_of(g))) dut (
            .clk     (clk),
            .rstn    (rstn),
            .lsu     (bus),
            .err_clr (err_clr),
            .err_ovr (ovr_o[g]),
            .err_oor (oor_o[g])
         );
      end
   endgenerate

   int n_chk = 0;
   int n_fail = 0;

   // Model: per-instance memory image, pending read with its response edge.
   logic [31:0] m_mem [N][1024];
   bit          m_pend [N];
   int          m_resp [N];
   logic [31:0] m_data [N];
   logic [31:0] m_rd   [N];
   bit          m_ovr  [N];
   bit          m_oor  [N];
   int          edge_no = 0;
   int          vld_cnt  [N];
   int          vld_edge [N];
   int          acc_edge = 0;
   int          lat_want [N] = '{2, 1, 4};
   int          cnt_want;

   task automatic check(input string name, input int inst, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s inst%0d edge %0d: got %h want %h", name, inst, edge_no, got, want);
      end
   endtask

   task automatic model_edge(input int i);
      int          e;
      bit          cur_busy, inr, s_ovr, s_oor;
      int          idx;
      logic [31:0] mask;
      e        = edge_no;
      cur_busy = m_pend[i] && (e - 1) <= m_resp[i];
      if (m_pend[i] && e > m_resp[i]) m_pend[i] = 1'b0;
      s_ovr = 1'b0;
      s_oor = 1'b0;
      if (we != 0 || re != 0) begin
         if (cur_busy) begin
            s_ovr = 1'b1;
         end else begin
            inr = (a < 32'h1000);
            idx = int'(a[11:2]);
            if (we != 0 && re != 0) s_ovr = 1'b1;
            if (!inr) s_oor = 1'b1;
            if (we != 0 && inr) begin
               for (int l = 0; l < 4; l++)
                  if (we[l]) m_mem[i][idx][8*l +: 8] = wd[8*l +: 8];
            end
            if (we == 0 && re != 0) begin
               mask = 32'h0;
               for (int l = 0; l < 4; l++)
                  if (re[l]) mask[8*l +: 8] = 8'hFF;
               m_pend[i] = 1'b1;
               m_resp[i] = e + wait_of(i);
               m_data[i] = inr ? (m_mem[i][idx] & mask) : 32'h0;
            end
         end
      end
      m_ovr[i] = s_ovr || (m_ovr[i] && !err_clr);
      m_oor[i] = s_oor || (m_oor[i] && !err_clr);
      if (m_pend[i] && e == m_resp[i]) m_rd[i] = m_data[i];
   endtask

   task automatic req(input logic [31:0] a_, input logic [3:0] we_, input logic [31:0] wd_,
                      input logic [3:0] re_, input logic clr_);
      @(negedge clk);
      #1;
      a = a_; we = we_; wd = wd_; re = re_; err_clr = clr_;
      if (re_ != 0 && we_ == 0) acc_edge = edge_no + 1;
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      #1;
      a = 0; we = 0; wd = 0; re = 0; err_clr = 0;
      repeat (n) @(negedge clk);
      #2;
   endtask

   task automatic lit_all_rd(input string name, input logic [31:0] want);
      for (int i = 0; i < N; i++) check(name, i, rd_o[i], want);
   endtask

   task automatic lit_all_cnt(input string name, input int want);
      for (int i = 0; i < N; i++) check(name, i, 32'(vld_cnt[i]), 32'(want));
   endtask

   initial begin
      rstn = 1'b0;
      a = 0; we = 0; wd = 0; re = 0; err_clr = 0;
      for (int i = 0; i < N; i++) begin
         m_pend[i] = 0; m_rd[i] = 0; m_ovr[i] = 0; m_oor[i] = 0;
         vld_cnt[i] = 0; vld_edge[i] = 0; m_resp[i] = 0; m_data[i] = 0;
      end

      fork
         forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
               for (int i = 0; i < N; i++) begin
                  m_pend[i] = 0; m_rd[i] = 0; m_ovr[i] = 0; m_oor[i] = 0;
               end
            end else begin
               edge_no++;
               for (int i = 0; i < N; i++) model_edge(i);
            end
         end
         forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
               check("vld",  i, 32'(vld_o[i]),  32'(m_pend[i] && edge_no == m_resp[i]));
               check("busy", i, 32'(busy_o[i]), 32'(m_pend[i] && edge_no <= m_resp[i]));
               check("rd",   i, rd_o[i], m_rd[i]);
               check("ovr",  i, 32'(ovr_o[i]),  32'(m_ovr[i]));
               check("oor",  i, 32'(oor_o[i]),  32'(m_oor[i]));
               if (vld_o[i]) begin
                  vld_cnt[i]++;
                  vld_edge[i] = edge_no;
               end
            end
         end
         begin
            #50000;
            $display("FAIL watchdog: got timeout want finish");
            $fatal(1, "watchdog");
         end
      join_none

      repeat (3) @(negedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
         check("rst_rd",   i, rd_o[i], 32'h0);
         check("rst_vld",  i, 32'(vld_o[i]), 32'h0);
         check("rst_busy", i, 32'(busy_o[i]), 32'h0);
         check("rst_ovr",  i, 32'(ovr_o[i]), 32'h0);
         check("rst_oor",  i, 32'(oor_o[i]), 32'h0);
      end
      rstn = 1'b1;

      // full word write, read on the very next cycle
      req(32'h10, 4'hF, 32'hDEADBEEF, 4'h0, 1'b0);
      req(32'h10, 4'h0, 32'h0, 4'hF, 1'b0);
      idle(8);
      lit_all_rd("raw_full", 32'hDEADBEEF);
      check("model_raw_full", 0, m_rd[0], 32'hDEADBEEF);
      for (int i = 0; i < N; i++) check("latency", i, 32'(vld_edge[i] - acc_edge + 1), 32'(lat_want[i]));
      lit_all_cnt("vld_cnt1", 1);

      // byte-lane write then full and partial reads
      req(32'h10, 4'b0010, 32'h0000AA00, 4'h0, 1'b0);
      idle(1);
      req(32'h10, 4'h0, 32'h0, 4'hF, 1'b0);
      idle(8);
      lit_all_rd("lane_full", 32'hDEADAAEF);
      check("model_lane_full", 2, m_rd[2], 32'hDEADAAEF);
      req(32'h10, 4'h0, 32'h0, 4'b0011, 1'b0);
      idle(8);
      lit_all_rd("lane_part", 32'h0000AAEF);

      // write while busy is ignored, read completes
      req(32'h10, 4'h0, 32'h0, 4'hF, 1'b0);
      req(32'h10, 4'hF, 32'h11111111, 4'h0, 1'b0);
      idle(8);
      for (int i = 0; i < N; i++) check("ovr_set", i, 32'(ovr_o[i]), 32'h1);
      lit_all_rd("ovr_read", 32'hDEADAAEF);
      req(32'h10, 4'h0, 32'h0, 4'hF, 1'b0);
      idle(8);
      lit_all_rd("ovr_unchanged", 32'hDEADAAEF);
      req(32'h0, 4'h0, 32'h0, 4'h0, 1'b1);
      idle(2);
      for (int i = 0; i < N; i++) check("ovr_clr", i, 32'(ovr_o[i]), 32'h0);

      // out of range
      req(32'h0, 4'hF, 32'hCAFEF00D, 4'h0, 1'b0);
      req(32'h1000, 4'hF, 32'h12345678, 4'h0, 1'b0);
      idle(2);
      for (int i = 0; i < N; i++) check("oor_set", i, 32'(oor_o[i]), 32'h1);
      req(32'h0, 4'h0, 32'h0, 4'hF, 1'b0);
      idle(8);
      lit_all_rd("oor_word0", 32'hCAFEF00D);
      req(32'h1000, 4'h0, 32'h0, 4'hF, 1'b0);
      idle(8);
      lit_all_rd("oor_read", 32'h0);
      lit_all_cnt("vld_cnt7", 7);

      // write+read together while clearing: write done, read dropped, error wins
      req(32'h20, 4'hF, 32'hA5A5A5A5, 4'hF, 1'b1);
      idle(4);
      for (int i = 0; i < N; i++) begin
         check("clr_vs_ovr", i, 32'(ovr_o[i]), 32'h1);
         check("clr_oor",    i, 32'(oor_o[i]), 32'h0);
      end
      lit_all_cnt("both_no_vld", 7);
      req(32'h20, 4'h0, 32'h0, 4'hF, 1'b0);
      idle(8);
      lit_all_rd("both_write", 32'hA5A5A5A5);

      // reset right after a read is accepted
      req(32'h10, 4'h0, 32'h0, 4'hF, 1'b0);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      a = 0; re = 0;
      repeat (2) @(negedge clk);
      #1;
      rstn = 1'b1;
      idle(6);
      lit_all_cnt("rst_no_vld", 8);
      for (int i = 0; i < N; i++) check("rst_busy2", i, 32'(busy_o[i]), 32'h0);
      req(32'h10, 4'h0, 32'h0, 4'hF, 1'b0);
      idle(8);
      lit_all_rd("rst_keep", 32'hDEADAAEF);
      cnt_want = 9;
      lit_all_cnt("vld_cnt9", cnt_want);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/u_lsu_dmem.md
Name: u_lsu_dmem

Overview:
Data-memory responder on the far end of the execute stage's load/store interface. Accepts byte-lane write and read requests on lsu_a/lsu_we/lsu_wd/lsu_re and returns read data with a one-cycle lsu_vld pulse after a configurable number of wait states. Holds a word-organised local SRAM array and exposes a busy flag to the hazard unit. Also exposes sticky error flags for protocol violations and out-of-range addresses.

Parameters:
AW, 10, word-address width; the array holds 2**AW 32-bit words.
WAIT_RD, 1, extra wait cycles before read response (0..15).

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
lsu_a  input  32  byte address; bits [1:0] ignored, word index = lsu_a[AW+1:2]
lsu_we  input  4  byte-lane write enables; nonzero = write request
lsu_wd  input  32  write data, lane i = bits [8i+7:8i]
lsu_re  input  4  byte-lane read enables; nonzero = read request
lsu_vld  output  1  read data valid, one-cycle pulse
lsu_rd  output  32  read data
busy  output  1  responder not idle; hazard must not issue requests
err_ovr  output  1  sticky: request arrived while busy, or we and re both nonzero
err_oor  output  1  sticky: address outside array
err_clr  input  1  synchronous clear of err_ovr and err_oor

Behaviour:
- Reset rstn asynchronous, active-low; clock clk. Reset values: lsu_vld=0, lsu_rd=0, busy=0, err_ovr=0, err_oor=0, FSM=IDLE, wait counter=0. Array contents are not reset and are preserved across reset.
- Request = (lsu_we!=0) | (lsu_re!=0), sampled at each rising edge. Inputs are level-sampled; the initiator holds them for exactly one cycle per request.
- In-range: lsu_a[31:AW+2]==0. Out-of-range requests set err_oor.
  - Out-of-range write: dropped.
  - Out-of-range read: completes normally with lsu_rd=0.
- FSM states: IDLE, WAIT, RESP.
- IDLE, write request (we!=0, re==0): at that edge, each enabled lane is written into the word; other lanes are unchanged. FSM stays IDLE. No lsu_vld and no busy.
- IDLE, read request (re!=0, we==0): latch word index, re mask and range flag.
  - WAIT_RD==0: go to RESP.
  - Otherwise: go to WAIT with counter=WAIT_RD-1.
- WAIT: if counter==0 go to RESP, else decrement counter.
- RESP: drive lsu_vld=1 for that cycle only. lsu_rd = array word with disabled lanes forced to 0 (0 if out of range). Next state IDLE.
  - lsu_rd holds its value after the pulse until the next RESP.
  - lsu_rd is not sign-extended; extension is done upstream.
- Latency: a read accepted at edge T has lsu_vld high in cycle T+1+WAIT_RD (WAIT_RD=0 gives the pulse in the cycle immediately after acceptance).
- busy = (FSM!=IDLE). It is high from the cycle after read acceptance through the RESP cycle inclusive.
- Read-after-write to the same word on consecutive requests returns the newly written data. The write is complete at the edge it is accepted.
- Request while busy: ignored (no write, no read); sets err_ovr. The in-flight read is unaffected.
- we!=0 and re!=0 in the same cycle: the write is performed, the read is dropped, err_ovr is set.
- Errors are sticky until err_clr=1 at an edge.
  - A new error in the same cycle as err_clr: the error wins (flag set).
- Reset mid-read: FSM returns to IDLE, no lsu_vld is issued, the pending read is discarded.

Test Plan:
- Reset -> lsu_vld=0, lsu_rd=0, busy=0, err_ovr=0, err_oor=0.
- Write full word (WAIT_RD=1): write a=0x10, we=1111, wd=0xDEADBEEF; next cycle read a=0x10, re=1111 -> busy high 2 cycles, lsu_vld pulses in cycle T+2 with lsu_rd=0xDEADBEEF.
- Byte-lane write: from the 0xDEADBEEF word, write a=0x10, we=0010, wd=0x0000AA00, then read with re=1111 -> 0xDEADAAEF. Read with re=0011 -> 0x0000AAEF.
- Overlap: issue a read, then a write to a=0x10 while busy -> err_ovr=1, array unchanged, the original read still returns. Then err_clr -> err_ovr=0.
- Out of range (AW=10): write a=0x1000, wd=0x12345678 -> err_oor=1, word 0 unchanged. Read a=0x1000 -> lsu_vld with lsu_rd=0.
- Latency sweep: WAIT_RD=0 -> lsu_vld at T+1. WAIT_RD=3 -> lsu_vld at T+4. In both cases assert rstn low during WAIT -> no lsu_vld; a read issued after reset returns the pre-reset written data.
